// File: rtl/hub75_pkg.sv
// ============================================================================
// hub75_pkg : shared FSM states and framebuffer word field offsets
// Rev 1.0
// ============================================================================
`default_nettype none

package hub75_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_LATCH   = 2'd2,
      ST_DISPLAY = 2'd3
   } state_e;

   // Field index within rd_data = {r1,g1,b1,r0,g0,b0}; multiply by BITS for bit offset
   localparam int c_fld_b0 = 0;
   localparam int c_fld_g0 = 1;
   localparam int c_fld_r0 = 2;
   localparam int c_fld_b1 = 3;
   localparam int c_fld_g1 = 4;
   localparam int c_fld_r1 = 5;
   localparam int c_num_flds = 6;

endpackage

`default_nettype wire

// File: rtl/hub75_bcm_timer.sv
// ============================================================================
// hub75_bcm_timer : loadable down-counter, done while the count sits at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module hub75_bcm_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= value_i;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/hub75_bcm_driver.sv
// ============================================================================
// hub75_bcm_driver : HUB75 panel scanner with binary-coded-modulation planes
// Rev 1.0
// ============================================================================
`default_nettype none

module hub75_bcm_driver
   import hub75_pkg::*;
#(
   parameter int  COLS       = 64,
   parameter int  ROWS       = 32,
   parameter int  BITS       = 4,
   parameter int  BASE_TICKS = 8,
   localparam int SCAN       = ROWS / 2,
   localparam int ADDR_W     = $clog2(SCAN),
   localparam int COL_W      = $clog2(COLS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   output logic                rd_en,
   output logic [ADDR_W-1:0]   rd_row,
   output logic [COL_W-1:0]    rd_col,
   input  logic [6*BITS-1:0]   rd_data,
   output logic [1:0]          r,
   output logic [1:0]          g,
   output logic [1:0]          b,
   output logic [ADDR_W-1:0]   addr,
   output logic                latch,
   output logic                blank,
   output logic                led_clk,
   output logic                frame_start
);

   localparam int c_k_w     = $clog2(2*COLS + 2);
   localparam int c_plane_w = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int c_tick_w  = $clog2((BASE_TICKS << (BITS - 1)) + 1);

   localparam logic [c_k_w-1:0]     c_k_last     = c_k_w'(2*COLS + 1);
   localparam logic [c_k_w-1:0]     c_k_data_end = c_k_w'(2*COLS);
   localparam logic [c_plane_w-1:0] c_plane_last = c_plane_w'(BITS - 1);
   localparam logic [ADDR_W-1:0]    c_row_last   = ADDR_W'(SCAN - 1);

   state_e                 state_q;
   logic [c_k_w-1:0]       k_q;
   logic [ADDR_W-1:0]      row_q;
   logic [c_plane_w-1:0]   plane_q;
   logic                   rd_en_q;
   logic [ADDR_W-1:0]      rd_row_q;
   logic [COL_W-1:0]       rd_col_q;
   logic [1:0]             r_q, g_q, b_q;
   logic [ADDR_W-1:0]      addr_q;
   logic                   latch_q, blank_q, led_clk_q, frame_start_q;

   logic [c_k_w-1:0]       w_k_inc;
   logic                   w_plane_wrap;
   logic [c_plane_w-1:0]   w_plane_next;
   logic [ADDR_W-1:0]      w_row_next;
   logic [c_tick_w-1:0]    w_ticks;
   logic                   w_load;
   logic                   w_done;
   logic [c_num_flds-1:0]  w_bits;

   // Pick the active bit plane out of every colour field of the returned word
   for (genvar gi = 0; gi < c_num_flds; gi++) begin : g_fld
      logic [BITS-1:0] w_field;
      assign w_field    = rd_data[gi*BITS +: BITS];
      assign w_bits[gi] = w_field[plane_q];
   end

   assign w_k_inc      = k_q + c_k_w'(1);
   assign w_plane_wrap = (plane_q == c_plane_last);
   assign w_plane_next = w_plane_wrap ? '0 : plane_q + c_plane_w'(1);
   assign w_row_next   = !w_plane_wrap ? row_q :
                         (row_q == c_row_last) ? '0 : row_q + ADDR_W'(1);

   // Loaded during LATCH with N-1 so DISPLAY spans exactly N cycles
   assign w_ticks = (c_tick_w'(BASE_TICKS) << plane_q) - c_tick_w'(1);
   assign w_load  = (state_q == ST_LATCH);

   hub75_bcm_timer #(
      .WIDTH   (c_tick_w)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (w_load),
      .value_i (w_ticks),
      .done_o  (w_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         k_q           <= '0;
         row_q         <= '0;
         plane_q       <= '0;
         rd_en_q       <= 1'b0;
         rd_row_q      <= '0;
         rd_col_q      <= '0;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         addr_q        <= '0;
         latch_q       <= 1'b0;
         blank_q       <= 1'b1;
         led_clk_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         latch_q       <= 1'b0;
         rd_en_q       <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_q       <= ST_SHIFT;
                  k_q           <= '0;
                  row_q         <= '0;
                  plane_q       <= '0;
                  rd_en_q       <= 1'b1;
                  rd_row_q      <= '0;
                  rd_col_q      <= '0;
                  frame_start_q <= 1'b1;
               end
            end
            ST_SHIFT: begin
               // Data requested at k=2c arrives during k=2c+1
               if (k_q[0] && (k_q < c_k_data_end)) begin
                  r_q <= {w_bits[c_fld_r1], w_bits[c_fld_r0]};
                  g_q <= {w_bits[c_fld_g1], w_bits[c_fld_g0]};
                  b_q <= {w_bits[c_fld_b1], w_bits[c_fld_b0]};
               end
               if (k_q == c_k_last) begin
                  state_q   <= ST_LATCH;
                  latch_q   <= 1'b1;
                  addr_q    <= row_q;
                  led_clk_q <= 1'b0;
               end else begin
                  k_q       <= w_k_inc;
                  led_clk_q <= w_k_inc[0] && (w_k_inc > c_k_w'(2));
                  if (!w_k_inc[0] && (w_k_inc < c_k_data_end)) begin
                     rd_en_q  <= 1'b1;
                     rd_col_q <= COL_W'(w_k_inc >> 1);
                  end
               end
            end
            ST_LATCH: begin
               state_q <= ST_DISPLAY;
               blank_q <= 1'b0;
            end
            ST_DISPLAY: begin
               if (w_done) begin
                  blank_q <= 1'b1;
                  if (!enable) begin
                     state_q   <= ST_IDLE;
                     r_q       <= '0;
                     g_q       <= '0;
                     b_q       <= '0;
                     led_clk_q <= 1'b0;
                  end else begin
                     state_q       <= ST_SHIFT;
                     k_q           <= '0;
                     plane_q       <= w_plane_next;
                     row_q         <= w_row_next;
                     rd_en_q       <= 1'b1;
                     rd_row_q      <= w_row_next;
                     rd_col_q      <= '0;
                     frame_start_q <= w_plane_wrap && (row_q == c_row_last);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_en       = rd_en_q;
   assign rd_row      = rd_row_q;
   assign rd_col      = rd_col_q;
   assign r           = r_q;
   assign g           = g_q;
   assign b           = b_q;
   assign addr        = addr_q;
   assign latch       = latch_q;
   assign blank       = blank_q;
   assign led_clk     = led_clk_q;
   assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_hub75_bcm_driver.sv
// ============================================================================
// tb_hub75_bcm_driver : scoreboard bench for the HUB75 BCM driver
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hub75_bcm_driver;

   localparam int COLS       = 4;
   localparam int ROWS       = 4;
   localparam int BITS       = 2;
   localparam int BASE_TICKS = 2;
   localparam int SCAN       = ROWS / 2;
   localparam int ADDR_W     = $clog2(SCAN);
   localparam int COL_W      = $clog2(COLS);
   localparam int DW         = 6 * BITS;
   localparam int SHIFT_LEN  = 2*COLS + 2;
   localparam int FRAME_LEN  = SCAN*BITS*(SHIFT_LEN + 1) + SCAN*((BASE_TICKS << BITS) - BASE_TICKS);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_row;
   logic [COL_W-1:0]  rd_col;
   logic [DW-1:0]     rd_data = '0;
   logic [1:0]        r, g, b;
   logic [ADDR_W-1:0] addr;
   logic              latch, blank, led_clk, frame_start;

   logic              en_big = 1'b0;
   logic              big_rd_en;
   logic [3:0]        big_rd_row;
   logic [5:0]        big_rd_col;
   logic [23:0]       big_rd_data = 24'hA5C3F0;
   logic [1:0]        big_r, big_g, big_b;
   logic [3:0]        big_addr;
   logic              big_latch, big_blank, big_led_clk, big_fs;

   int                n_cmp = 0;
   int                n_err = 0;
   int                cyc = 0;
   int                tb_plane = 0;
   logic              prev_lc = 1'b0;
   logic [5:0]        exp_q[$];
   logic [5:0]        obs_q[$];

   hub75_bcm_driver #(
      .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .BASE_TICKS(BASE_TICKS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
      .r(r), .g(g), .b(b), .addr(addr), .latch(latch), .blank(blank),
      .led_clk(led_clk), .frame_start(frame_start)
   );

   hub75_bcm_driver dut_big (
      .clk(clk), .rst_n(rst_n), .enable(en_big),
      .rd_en(big_rd_en), .rd_row(big_rd_row), .rd_col(big_rd_col), .rd_data(big_rd_data),
      .r(big_r), .g(big_g), .b(big_b), .addr(big_addr), .latch(big_latch), .blank(big_blank),
      .led_clk(big_led_clk), .frame_start(big_fs)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] fb_word(input logic [ADDR_W-1:0] row, input logic [COL_W-1:0] col);
      int v;
      v = (int'(row) * 8 + int'(col) + 1) * 40503;
      return DW'(v ^ (v >> 11));
   endfunction

   // Bit p of each field, packed as {r1,r0,g1,g0,b1,b0}
   function automatic logic [5:0] exp_rgb(input logic [DW-1:0] w, input int p);
      logic [DW-1:0] s;
      s = w >> p;
      return {s[5*BITS], s[2*BITS], s[4*BITS], s[1*BITS], s[3*BITS], s[0]};
   endfunction

   // Framebuffer model: answers one cycle after rd_en and records what must appear
   always @(posedge clk) begin
      logic [DW-1:0] w;
      cyc <= cyc + 1;
      if (rst_n && rd_en) begin
         w = fb_word(rd_row, rd_col);
         rd_data <= w;
         exp_q.push_back(exp_rgb(w, tb_plane));
      end
   end

   // Capture pixels on led_clk rising; track the plane being shifted
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_start) tb_plane = 0;
         if (led_clk && !prev_lc) obs_q.push_back({r, g, b});
         if (latch) tb_plane = (tb_plane + 1) % BITS;
      end
      prev_lc = led_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({r, g, b, led_clk, latch, rd_en, frame_start, addr, rd_row, rd_col} !== '0) begin
         n_err++;
         $display("FAIL reset_zero: got %b want all zero",
                  {r, g, b, led_clk, latch, rd_en, frame_start, addr, rd_row, rd_col});
      end
      n_cmp++;
      if (blank !== 1'b1) begin
         n_err++;
         $display("FAIL reset_blank: got %b want 1", blank);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({blank, rd_en, latch, frame_start} !== 4'b1000) begin
         n_err++;
         $display("FAIL idle_hold: got %b want 1000", {blank, rd_en, latch, frame_start});
      end
   endtask

   task automatic test_first_frame();
      int   guard, shift_len, pulses, disp, t0;
      logic pl;
      enable = 1'b1;
      guard  = 0;
      while (frame_start !== 1'b1 && guard < 4) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (frame_start !== 1'b1 || rd_en !== 1'b1 || rd_col !== '0 || rd_row !== '0) begin
         n_err++;
         $display("FAIL first_shift: got fs=%b rd_en=%b col=%0d row=%0d want 1 1 0 0",
                  frame_start, rd_en, rd_col, rd_row);
      end
      t0 = cyc;
      for (int i = 0; i < SCAN*BITS; i++) begin
         shift_len = 0;
         pulses    = 0;
         pl        = 1'b0;
         while (latch !== 1'b1 && shift_len < 40) begin
            if (led_clk && !pl) pulses++;
            pl = led_clk;
            shift_len++;
            @(negedge clk);
         end
         n_cmp++;
         if (shift_len != SHIFT_LEN) begin
            n_err++;
            $display("FAIL shift_len[%0d]: got %0d want %0d", i, shift_len, SHIFT_LEN);
         end
         n_cmp++;
         if (pulses != COLS) begin
            n_err++;
            $display("FAIL led_clk_pulses[%0d]: got %0d want %0d", i, pulses, COLS);
         end
         n_cmp++;
         if (addr !== ADDR_W'(i / BITS) || blank !== 1'b1) begin
            n_err++;
            $display("FAIL latch_addr[%0d]: got addr=%0d blank=%b want %0d 1", i, addr, blank, i / BITS);
         end
         @(negedge clk);
         n_cmp++;
         if (latch !== 1'b0) begin
            n_err++;
            $display("FAIL latch_width[%0d]: got latch=%b want 0", i, latch);
         end
         disp = 0;
         while (blank !== 1'b1 && disp < 40) begin
            disp++;
            @(negedge clk);
         end
         n_cmp++;
         if (disp != (BASE_TICKS << (i % BITS))) begin
            n_err++;
            $display("FAIL display_len[%0d]: got %0d want %0d", i, disp, BASE_TICKS << (i % BITS));
         end
      end
      n_cmp++;
      if (frame_start !== 1'b1 || (cyc - t0) != FRAME_LEN) begin
         n_err++;
         $display("FAIL frame_period: got fs=%b period=%0d want 1 %0d", frame_start, cyc - t0, FRAME_LEN);
      end
   endtask

   task automatic test_pixel_data();
      logic [5:0] o, e;
      n_cmp++;
      if (obs_q.size() != SCAN*BITS*COLS) begin
         n_err++;
         $display("FAIL pixel_count: got %0d want %0d", obs_q.size(), SCAN*BITS*COLS);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bxxxxxx;
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL pixel_rgb: got %b want %b", o, e);
         end
      end
   endtask

   task automatic test_enable_drop();
      int         guard, seen, disp, act;
      logic [5:0] o, e;
      guard = 0;
      seen  = 0;
      while (seen < 2 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (latch === 1'b1) seen++;
      end
      @(negedge clk);
      while (blank !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (rd_row !== ADDR_W'(1) || rd_en !== 1'b1) begin
         n_err++;
         $display("FAIL drop_point: got row=%0d rd_en=%b want 1 1", rd_row, rd_en);
      end
      enable = 1'b0;
      guard  = 0;
      while (latch !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (latch !== 1'b1 || addr !== ADDR_W'(1)) begin
         n_err++;
         $display("FAIL drop_latch: got latch=%b addr=%0d want 1 1", latch, addr);
      end
      @(negedge clk);
      disp = 0;
      while (blank !== 1'b1 && disp < 40) begin
         disp++;
         @(negedge clk);
      end
      n_cmp++;
      if (disp != BASE_TICKS) begin
         n_err++;
         $display("FAIL drop_display: got %0d want %0d", disp, BASE_TICKS);
      end
      act = 0;
      repeat (20) begin
         if (latch || rd_en || led_clk || !blank || frame_start || ({r, g, b} != '0)) act++;
         @(negedge clk);
      end
      n_cmp++;
      if (act != 0) begin
         n_err++;
         $display("FAIL idle_quiet: got %0d active cycles want 0", act);
      end
      n_cmp++;
      if (obs_q.size() != 3*COLS) begin
         n_err++;
         $display("FAIL drop_pixel_count: got %0d want %0d", obs_q.size(), 3*COLS);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bxxxxxx;
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL drop_pixel_rgb: got %b want %b", o, e);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drop_leftover: got %0d pending want 0", exp_q.size());
      end
      enable = 1'b1;
      guard  = 0;
      while (frame_start !== 1'b1 && guard < 4) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (frame_start !== 1'b1 || rd_row !== '0) begin
         n_err++;
         $display("FAIL restart_row: got fs=%b row=%0d want 1 0", frame_start, rd_row);
      end
      guard = 0;
      while (latch !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (latch !== 1'b1 || addr !== '0) begin
         n_err++;
         $display("FAIL restart_addr: got latch=%b addr=%0d want 1 0", latch, addr);
      end
      @(negedge clk);
      disp = 0;
      while (blank !== 1'b1 && disp < 40) begin
         disp++;
         @(negedge clk);
      end
      n_cmp++;
      if (disp != BASE_TICKS) begin
         n_err++;
         $display("FAIL restart_plane: got display %0d want %0d", disp, BASE_TICKS);
      end
   endtask

   task automatic test_async_reset();
      int guard;
      guard = 0;
      while (!(latch === 1'b1 && addr === ADDR_W'(1)) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      n_cmp++;
      if (blank !== 1'b0 || rd_row !== ADDR_W'(1)) begin
         n_err++;
         $display("FAIL pre_reset_display: got blank=%b row=%0d want 0 1", blank, rd_row);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({r, g, b, led_clk, latch, rd_en, frame_start, addr, rd_row, rd_col} !== '0 || blank !== 1'b1) begin
         n_err++;
         $display("FAIL async_reset: got %b blank=%b want all zero blank=1",
                  {r, g, b, led_clk, latch, rd_en, frame_start, addr, rd_row, rd_col}, blank);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      obs_q.delete();
      exp_q.delete();
      n_cmp++;
      if (frame_start !== 1'b1 || rd_row !== '0 || rd_en !== 1'b1) begin
         n_err++;
         $display("FAIL reset_resume: got fs=%b row=%0d rd_en=%b want 1 0 1", frame_start, rd_row, rd_en);
      end
   endtask

   task automatic test_back_to_back();
      int         guard, t0;
      logic [5:0] o, e;
      t0    = cyc;
      guard = 0;
      @(negedge clk);
      while (frame_start !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if ((cyc - t0) != FRAME_LEN) begin
         n_err++;
         $display("FAIL b2b_period: got %0d want %0d", cyc - t0, FRAME_LEN);
      end
      n_cmp++;
      if (obs_q.size() != SCAN*BITS*COLS) begin
         n_err++;
         $display("FAIL b2b_pixel_count: got %0d want %0d", obs_q.size(), SCAN*BITS*COLS);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bxxxxxx;
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL b2b_pixel_rgb: got %b want %b", o, e);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_big_panel();
      int guard, shift_len, disp;
      en_big = 1'b1;
      guard  = 0;
      while (big_fs !== 1'b1 && guard < 4) begin
         @(negedge clk);
         guard++;
      end
      shift_len = 0;
      while (big_latch !== 1'b1 && shift_len < 300) begin
         shift_len++;
         @(negedge clk);
      end
      n_cmp++;
      if (shift_len != 130) begin
         n_err++;
         $display("FAIL big_shift_len: got %0d want 130", shift_len);
      end
      for (int p = 0; p < 4; p++) begin
         guard = 0;
         while (big_latch !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
         end
         @(negedge clk);
         disp = 0;
         while (big_blank !== 1'b1 && disp < 200) begin
            disp++;
            @(negedge clk);
         end
         n_cmp++;
         if (disp != (8 << p)) begin
            n_err++;
            $display("FAIL big_display[%0d]: got %0d want %0d", p, disp, 8 << p);
         end
      end
      en_big = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_pixel_data();
      test_enable_drop();
      test_async_reset();
      test_back_to_back();
      test_big_panel();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
